nv_async_req_arb: RTL and testbench

- Round-robin arbiter for a shared local resource, used by NREQ requesters in foreign clock domains.
- Each requester runs a 4-phase level req/ack handshake. Its req is brought into the core domain through a 3-flop synchronizer.
- Winners are offered to the local datapath over a valid/ready grant port and held until the datapath signals done.
- Sits at the boundary between slave-domain control logic and core-domain shared engines.

---
 rtl/nv_async_arb_pkg.sv | 19 +
 rtl/nv_req_sync3.sv | 23 ++
 rtl/nv_async_req_arb.sv | 172 +++++++++++++++++
 tb/tb_nv_async_req_arb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_async_arb_pkg.sv
// Shared types for the async request arbiter: requester/arbiter FSM states and sync depth.
package nv_async_arb_pkg;

  localparam int SYNC_DEPTH = 3;

  typedef enum logic [1:0] {
    R_IDLE,
    R_PEND,
    R_SERV,
    R_ACKH
  } req_state_e;

  typedef enum logic [1:0] {
    A_ARB,
    A_OFFER,
    A_WORK
  } arb_state_e;

endpackage

// File: rtl/nv_req_sync3.sv
// Single-bit SYNC_DEPTH-flop synchronizer into clk; q follows d after SYNC_DEPTH edges.
module nv_req_sync3
  import nv_async_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d};
    end
  end

  assign q = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/nv_async_req_arb.sv
// Round-robin arbiter for 4-phase async requesters; req rise to gnt_valid 4 cycles, offer held until gnt_ready.
// Optional A_WORK watchdog under NV_ASYNC_ARB_TIMEOUT_EN (TO_W-bit counter, expiry acts as done plus proto_err).
module nv_async_req_arb
  import nv_async_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int TO_W = 10
) (
  input  logic            nvdla_core_clk,
  input  logic            nvdla_core_rstn,
  input  logic [NREQ-1:0] async_req,
  output logic [NREQ-1:0] async_ack,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_id,
  input  logic            gnt_ready,
  input  logic            done,
  output logic            busy,
  output logic            proto_err
);

  logic [NREQ-1:0] req_s;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] ack_nxt;
  arb_state_e      a_q, a_nxt;
  req_state_e      r_q   [NREQ];
  req_state_e      r_nxt [NREQ];
  logic [IDW-1:0]  ptr_q, ptr_nxt, gid_nxt;
  logic            gv_nxt, busy_nxt, perr_nxt;
  logic            accept, finish, to_hit;
  logic            pick_vld;
  logic [IDW-1:0]  pick_id;

  genvar g;
  for (g = 0; g < NREQ; g++) begin : g_sync
    nv_req_sync3 u_sync (
      .clk   (nvdla_core_clk),
      .rst_n (nvdla_core_rstn),
      .d     (async_req[g]),
      .q     (req_s[g])
    );
  end

  // First eligible index at or after the pointer, wrapping at NREQ.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] e, input logic [IDW-1:0] p);
    logic [IDW:0] r;
    int           idx;
    r = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(p) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!r[IDW] && e[idx]) r = {1'b1, IDW'(idx)};
    end
    return r;
  endfunction

  // An idle requester with req_s high competes in the same cycle it becomes pending.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_s[i] && ((r_q[i] == R_IDLE) || (r_q[i] == R_PEND));
    end
  end

  assign {pick_vld, pick_id} = rr_pick(elig, ptr_q);
  assign accept = (a_q == A_OFFER) && gnt_ready;
  assign finish = (a_q == A_WORK) && (done || to_hit);

`ifdef NV_ASYNC_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      to_cnt_q <= '0;
    end else if (a_q != A_WORK) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign to_hit = (a_q == A_WORK) && (&to_cnt_q);
`else
  logic [TO_W-1:0] unused_to_w;
  assign unused_to_w = '0;
  assign to_hit      = 1'b0;
`endif

  always_comb begin
    a_nxt    = a_q;
    gv_nxt   = gnt_valid;
    gid_nxt  = gnt_id;
    busy_nxt = busy;
    ptr_nxt  = ptr_q;
    perr_nxt = 1'b0;
    ack_nxt  = '0;
    case (a_q)
      A_ARB: begin
        if (pick_vld) begin
          a_nxt   = A_OFFER;
          gv_nxt  = 1'b1;
          gid_nxt = pick_id;
        end
      end
      A_OFFER: begin
        if (gnt_ready) begin
          a_nxt    = A_WORK;
          gv_nxt   = 1'b0;
          busy_nxt = 1'b1;
          ptr_nxt  = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
      end
      A_WORK: begin
        // Completion and the next arbitration share a cycle so a new offer follows done by one cycle.
        if (finish) begin
          busy_nxt = 1'b0;
          if (pick_vld) begin
            a_nxt   = A_OFFER;
            gv_nxt  = 1'b1;
            gid_nxt = pick_id;
          end else begin
            a_nxt = A_ARB;
          end
        end
      end
      default: a_nxt = A_ARB;
    endcase
    if (done && (a_q != A_WORK)) perr_nxt = 1'b1;
    if (to_hit && !done) perr_nxt = 1'b1;

    for (int i = 0; i < NREQ; i++) begin
      r_nxt[i] = r_q[i];
      case (r_q[i])
        R_IDLE: if (req_s[i]) r_nxt[i] = R_PEND;
        R_PEND: begin
          if (!req_s[i]) begin
            r_nxt[i] = R_IDLE;
            perr_nxt = 1'b1;
          end
        end
        R_SERV: if (finish && (gnt_id == IDW'(i))) r_nxt[i] = R_ACKH;
        R_ACKH: if (!req_s[i]) r_nxt[i] = R_IDLE;
      endcase
      // An accepted offer is served even if its request was withdrawn meanwhile.
      if (accept && (gnt_id == IDW'(i))) r_nxt[i] = R_SERV;
      ack_nxt[i] = (r_nxt[i] == R_ACKH);
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      a_q       <= A_ARB;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
      ptr_q     <= '0;
      async_ack <= '0;
      for (int i = 0; i < NREQ; i++) r_q[i] <= R_IDLE;
    end else begin
      a_q       <= a_nxt;
      gnt_valid <= gv_nxt;
      gnt_id    <= gid_nxt;
      busy      <= busy_nxt;
      proto_err <= perr_nxt;
      ptr_q     <= ptr_nxt;
      async_ack <= ack_nxt;
      for (int i = 0; i < NREQ; i++) r_q[i] <= r_nxt[i];
    end
  end

endmodule

// File: tb/tb_nv_async_req_arb.sv
// Directed vector bench for nv_async_req_arb: cycle table for a single request plus multi-cycle sequences.
module tb_nv_async_req_arb;

  localparam logic [8:0] MALL  = 9'b1_1111_1111;
  localparam logic [8:0] MNOID = 9'b1_1111_0011;

  logic       clk       = 1'b0;
  logic       rstn      = 1'b0;
  logic [3:0] async_req = 4'b0;
  logic [3:0] async_ack;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       gnt_ready = 1'b0;
  logic       done      = 1'b0;
  logic       busy;
  logic       proto_err;

  int         nvec = 0;
  int         nmis = 0;
  logic       emu_on = 1'b0;
  logic [3:0] rearm  = 4'b0;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic       dn;
    logic [8:0] exp;  // {ack[3:0], gnt_valid, gnt_id[1:0], busy, proto_err}
  } vec_t;

  vec_t tbl [17];

  always #5 clk = ~clk;

  nv_async_req_arb #(.NREQ(4), .IDW(2), .TO_W(4)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .async_req       (async_req),
    .async_ack       (async_ack),
    .gnt_valid       (gnt_valid),
    .gnt_id          (gnt_id),
    .gnt_ready       (gnt_ready),
    .done            (done),
    .busy            (busy),
    .proto_err       (proto_err)
  );

  function automatic vec_t mk(input logic [3:0] rq, input logic rd, input logic dn, input logic [8:0] ex);
    vec_t v;
    v.req = rq;
    v.rdy = rd;
    v.dn  = dn;
    v.exp = ex;
    return v;
  endfunction

  function automatic logic [8:0] obs();
    return {async_ack, gnt_valid, gnt_id, busy, proto_err};
  endfunction

  task automatic chk(input string nm, input logic [8:0] got, input logic [8:0] exp, input logic [8:0] msk);
    nvec++;
    if ((got & msk) !== (exp & msk)) begin
      nmis++;
      $display("FAIL %s: got %b, expected %b (mask %b)", nm, got, exp, msk);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // One clock; sample 1ns after the edge. Optionally plays the requester side of the 4-phase handshake.
  task automatic step();
    @(posedge clk);
    #1;
    if (emu_on) begin
      for (int i = 0; i < 4; i++) begin
        if (async_ack[i] && async_req[i]) async_req[i] = 1'b0;
        else if (!async_ack[i] && !async_req[i] && rearm[i]) async_req[i] = 1'b1;
      end
    end
  endtask

  task automatic wait_grant(input string nm, input int exp_id);
    int n;
    int got;
    n = 0;
    while (!gnt_valid && n < 40) begin
      step();
      n++;
    end
    got = gnt_valid ? int'(gnt_id) : -1;
    chk_int(nm, got, exp_id);
  endtask

  task automatic drain(input string nm);
    emu_on    = 1'b0;
    async_req = 4'b0;
    gnt_ready = 1'b0;
    done      = 1'b0;
    repeat (10) step();
    chk(nm, obs(), 9'b0, MNOID);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_order [5];
    int perr_n;
    int gv_n;
    exp_order = '{0, 1, 2, 3, 0};

    for (int r = 0; r < 3; r++) tbl[r] = mk(4'b0001, 1'b0, 1'b0, 9'b0000_0_00_0_0);
    for (int r = 3; r < 6; r++) tbl[r] = mk(4'b0001, 1'b0, 1'b0, 9'b0000_1_00_0_0);
    tbl[6] = mk(4'b0001, 1'b1, 1'b0, 9'b0000_0_00_1_0);
    for (int r = 7; r < 10; r++) tbl[r] = mk(4'b0001, 1'b0, 1'b0, 9'b0000_0_00_1_0);
    tbl[10] = mk(4'b0001, 1'b0, 1'b1, 9'b0001_0_00_0_0);
    for (int r = 11; r < 14; r++) tbl[r] = mk(4'b0000, 1'b0, 1'b0, 9'b0001_0_00_0_0);
    tbl[14] = mk(4'b0000, 1'b0, 1'b0, 9'b0000_0_00_0_0);
    tbl[15] = mk(4'b0000, 1'b0, 1'b1, 9'b0000_0_00_0_1);
    tbl[16] = mk(4'b0000, 1'b0, 1'b0, 9'b0000_0_00_0_0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset state", obs(), 9'b0, MALL);
    rstn = 1'b1;
    step();
    step();

    // Single request walked cycle by cycle, then done while idle.
    for (int r = 0; r < 17; r++) begin
      async_req = tbl[r].req;
      gnt_ready = tbl[r].rdy;
      done      = tbl[r].dn;
      step();
      chk($sformatf("t1 row %0d", r), obs(), tbl[r].exp, tbl[r].exp[4] ? MALL : MNOID);
    end
    done = 1'b0;

    // Fresh pointer, then all four requesting with ready tied high.
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    emu_on    = 1'b1;
    rearm     = 4'b0001;
    async_req = 4'b1111;
    gnt_ready = 1'b1;
    for (int gi = 0; gi < 5; gi++) begin
      wait_grant($sformatf("t2 grant %0d", gi), exp_order[gi]);
      if (gi == 4) rearm = 4'b0;
      step();
      step();
      done = 1'b1;
      step();
      done = 1'b0;
    end
    drain("t2 idle");

    // Back-to-back: next offer one cycle after done.
    async_req = 4'b0110;
    wait_grant("t3 first grant", 1);
    gnt_ready = 1'b1;
    step();
    gnt_ready = 1'b0;
    step();
    chk("t3 busy", obs(), 9'b0000_0_00_1_0, MNOID);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t3 back-to-back", obs(), 9'b0010_1_10_0_0, MALL);
    gnt_ready = 1'b1;
    step();
    gnt_ready = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    drain("t3 idle");

    // Withdrawn request while requester 0 is served.
    async_req = 4'b0001;
    wait_grant("t4 grant", 0);
    gnt_ready = 1'b1;
    step();
    gnt_ready = 1'b0;
    perr_n = 0;
    gv_n   = 0;
    async_req = 4'b1001;
    repeat (4) begin
      step();
      if (proto_err) perr_n++;
      if (gnt_valid) gv_n++;
    end
    async_req = 4'b0001;
    repeat (7) begin
      step();
      if (proto_err) perr_n++;
      if (gnt_valid) gv_n++;
    end
    chk_int("t4 proto_err pulses", perr_n, 1);
    chk_int("t4 offers during job", gv_n, 0);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t4 ack0", obs(), 9'b0001_0_00_0_0, MNOID);
    drain("t4 idle");

    // Asynchronous reset mid-job, requester keeps req high.
    async_req = 4'b0010;
    wait_grant("t5 grant", 1);
    gnt_ready = 1'b1;
    step();
    gnt_ready = 1'b0;
    step();
    chk("t5 busy", obs(), 9'b0000_0_00_1_0, MNOID);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5 async reset", obs(), 9'b0, MALL);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) step();
    chk_int("t5 no grant before 4 edges", int'(gnt_valid), 0);
    step();
    chk_int("t5 regrant", gnt_valid ? int'(gnt_id) : -1, 1);
    gnt_ready = 1'b1;
    step();
    gnt_ready = 1'b0;
    done = 1'b1;
    step();
    done = 1'b0;
    drain("t5 idle");

    // Job without done.
    async_req = 4'b0100;
    wait_grant("t6 grant", 2);
    gnt_ready = 1'b1;
    step();
    gnt_ready = 1'b0;
`ifdef NV_ASYNC_ARB_TIMEOUT_EN
    repeat (15) step();
    chk("t6 before timeout", obs(), 9'b0000_0_00_1_0, MNOID);
    step();
    chk("t6 timeout", obs(), 9'b0100_0_00_0_1, MNOID);
`else
    repeat (30) step();
    chk("t6 still busy", obs(), 9'b0000_0_00_1_0, MNOID);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t6 late done", obs(), 9'b0100_0_00_0_0, MNOID);
`endif
    drain("t6 idle");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
